oa_wb_sched: RTL
================

OA_WB_SCHED -- requirements
Module: oa_wb_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of oa_writer requesters (2..8).
REQ-002 SHALL have parameter REG_WIDTH, default 32, width of tile counters and configuration.
REQ-003 SHALL have clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have init_cfg  input  1  one-cycle pulse that latches tile_count and starts a new run.
REQ-006 SHALL have tile_count  input  REG_WIDTH  total tiles to grant; sampled only on init_cfg.
REQ-007 SHALL have write_oa_req  input  N_REQ  per-writer level request, held until granted.
REQ-008 SHALL have write_done  input  N_REQ  per-writer one-cycle pulse that ends its tile write-back.
REQ-009 SHALL have write_oa_granted  output  N_REQ  one-hot one-cycle grant pulse.
REQ-010 SHALL have icb_sel  output  $clog2(N_REQ)  index of the writer owning the ICB write port; drives the external ICB mux.
REQ-011 SHALL have icb_sel_vld  output  1  high while a writer owns the port (GRANT and BUSY).
REQ-012 SHALL have tiles_done  output  REG_WIDTH  count of completed tiles in the current run.
REQ-013 SHALL have oa_calc_over  output  1  level, high once tiles_done equals the latched tile_count.
REQ-014 SHALL have err_sticky  output  1  set on a protocol violation; cleared only by reset or init_cfg.

Function
REQ-015 SHALL implement states IDLE, ARB, GRANT, BUSY, OVER.
REQ-016 SHALL leave IDLE only on init_cfg: next state OVER if tile_count==0, else ARB.
REQ-017 In ARB, SHALL select one asserted write_oa_req by round-robin starting at rr_ptr, latch its index into icb_sel, and enter GRANT next cycle; SHALL stay in ARB if no request is asserted.
REQ-018 In GRANT, SHALL assert write_oa_granted[icb_sel] for exactly one cycle, then enter BUSY.
REQ-019 In BUSY, SHALL wait for write_done[icb_sel]; on it, SHALL increment tiles_done, set rr_ptr to icb_sel+1 modulo N_REQ, and enter OVER if the incremented count equals the latched tile_count, else ARB.
REQ-020 Minimum grant-to-grant spacing SHALL be 3 cycles: done cycle, then ARB cycle, then GRANT cycle.
REQ-021 A write_done from a non-owner, or any write_done outside BUSY/GRANT, SHALL be ignored for counting and SHALL set err_sticky.
REQ-022 write_done[icb_sel] in the GRANT cycle SHALL be accepted as completion, and the FSM SHALL then go directly to ARB or OVER.
REQ-023 In OVER, SHALL hold oa_calc_over=1, issue no grants, and ignore write_oa_req.
REQ-024 init_cfg in any state SHALL abort the current run in the same edge:
  - grant withdrawn and icb_sel_vld=0 next cycle;
  - tiles_done=0 and err_sticky=0;
  - rr_ptr=0;
  - new tile_count latched;
  - next state as in REQ-016.
REQ-025 tiles_done SHALL saturate at all-ones and never wrap.
REQ-026 write_oa_granted SHALL never have more than one bit set and SHALL only be high in GRANT.
REQ-027 All outputs SHALL be registered (Moore); no combinational path from write_oa_req or write_done to any output.

Reset
REQ-028 On rst_n low, SHALL asynchronously force:
  - state=IDLE, rr_ptr=0;
  - write_oa_granted=0, icb_sel=0, icb_sel_vld=0;
  - tiles_done=0, oa_calc_over=0, err_sticky=0;
  - latched tile_count=0.
REQ-029 Reset asserted mid-BUSY SHALL drop icb_sel_vld immediately; after release the block SHALL remain in IDLE until init_cfg.

Verification
REQ-030 N_REQ=2, init_cfg with tile_count=3, req=2'b11 held -> grants to 0,1,0 in order, each pulse 1 cycle; oa_calc_over=1 and tiles_done=3 one cycle after the third done.
REQ-031 init_cfg with tile_count=0 -> oa_calc_over=1 next cycle; no grant ever issued.
REQ-032 Owner 0 in BUSY, write_done[1] pulses -> tiles_done unchanged, err_sticky=1, still BUSY; write_done[0] then completes normally.
REQ-033 tile_count=4, init_cfg pulsed during the second BUSY -> next cycle icb_sel_vld=0, tiles_done=0, state ARB; 4 further grants are required to reach OVER.
REQ-034 Single requester with req held and done returned in the GRANT cycle -> grant pulses exactly 3 cycles apart; rst_n pulsed low mid-run -> all outputs 0 asynchronously, and no grant until the next init_cfg.

Source files
------------

// File: rtl/oa_wb_sched.sv
// Purpose : round-robin scheduler granting the shared ICB write port to N_REQ oa_writers, one tile at a time.
// Latency : all outputs registered; ARB->GRANT one cycle, and at least 3 cycles from grant to grant.
// Backpressure: a request is a level held until granted; the port stays owned until the owner's write_done.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   init_cfg            pulse: latch tile_count, clear counters/error, restart (aborts any run)
//   tile_count          tiles to grant in this run (sampled on init_cfg only)
//   write_oa_req        per-writer request level
//   write_done          per-writer completion pulse
//   write_oa_granted    one-hot, one-cycle grant pulse (GRANT state only)
//   icb_sel/_vld        current owner index for the external ICB mux, valid in GRANT/BUSY
//   tiles_done          completed tiles (saturating)
//   oa_calc_over        level, high in OVER
//   err_sticky          protocol violation seen since the last reset/init_cfg
module oa_wb_sched #(
  parameter int N_REQ     = 2,
  parameter int REG_WIDTH = 32,
  localparam int SEL_W    = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_cfg,
  input  logic [REG_WIDTH-1:0] tile_count,
  input  logic [N_REQ-1:0]     write_oa_req,
  input  logic [N_REQ-1:0]     write_done,
  output logic [N_REQ-1:0]     write_oa_granted,
  output logic [SEL_W-1:0]     icb_sel,
  output logic                 icb_sel_vld,
  output logic [REG_WIDTH-1:0] tiles_done,
  output logic                 oa_calc_over,
  output logic                 err_sticky
);

  localparam int SUM_W = SEL_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_GRANT, S_BUSY, S_OVER} state_t;

  state_t               state, nxt_state;
  logic [SEL_W-1:0]     rr_ptr, nxt_rr;
  logic [SEL_W-1:0]     nxt_sel;
  logic [REG_WIDTH-1:0] tile_cnt_q, nxt_tc;
  logic [REG_WIDTH-1:0] nxt_tiles, tiles_inc;
  logic                 nxt_err;
  // Set for one cycle after a completion taken in the GRANT cycle; it keeps
  // the following ARB cycle from arbitrating so grants stay >= 3 cycles apart.
  logic                 hold_q, nxt_hold;
  logic [N_REQ-1:0]     nxt_gnt;
  logic                 nxt_vld, nxt_over;

  logic [N_REQ-1:0]     own_mask;
  logic                 accept, stray;
  logic                 pick_vld;
  logic [SEL_W-1:0]     pick_sel;
  logic [SUM_W-1:0]     sum;

  // Round-robin pick: first asserted request scanning upward from rr_ptr.
  always_comb begin
    pick_vld = 1'b0;
    pick_sel = '0;
    sum      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr} + SUM_W'(k);
      if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
      if (!pick_vld && write_oa_req[sum[SEL_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_sel = sum[SEL_W-1:0];
      end
    end
  end

  // Only the owner's done in GRANT/BUSY counts; every other done bit is a violation.
  always_comb begin
    own_mask          = '0;
    own_mask[icb_sel] = (state == S_GRANT) || (state == S_BUSY);
    accept            = |(write_done & own_mask);
    stray             = |(write_done & ~own_mask);
    tiles_inc         = (&tiles_done) ? tiles_done : tiles_done + REG_WIDTH'(1);
  end

  always_comb begin
    nxt_state = state;
    nxt_rr    = rr_ptr;
    nxt_sel   = icb_sel;
    nxt_tc    = tile_cnt_q;
    nxt_tiles = tiles_done;
    nxt_err   = err_sticky | stray;
    nxt_hold  = 1'b0;

    case (state)
      S_ARB: begin
        if (!hold_q && pick_vld) begin
          nxt_sel   = pick_sel;
          nxt_state = S_GRANT;
        end
      end
      S_GRANT, S_BUSY: begin
        if (accept) begin
          nxt_tiles = tiles_inc;
          nxt_rr    = (icb_sel == SEL_W'(N_REQ - 1)) ? '0 : icb_sel + SEL_W'(1);
          nxt_state = (tiles_inc == tile_cnt_q) ? S_OVER : S_ARB;
          nxt_hold  = (state == S_GRANT);
        end else if (state == S_GRANT) begin
          nxt_state = S_BUSY;
        end
      end
      default: ; // IDLE and OVER wait for init_cfg
    endcase

    // init_cfg overrides everything above, including an error raised this cycle.
    if (init_cfg) begin
      nxt_tc    = tile_count;
      nxt_tiles = '0;
      nxt_err   = 1'b0;
      nxt_rr    = '0;
      nxt_hold  = 1'b0;
      nxt_state = (tile_count == '0) ? S_OVER : S_ARB;
    end

    nxt_gnt = '0;
    if (nxt_state == S_GRANT) nxt_gnt[nxt_sel] = 1'b1;
    nxt_vld  = (nxt_state == S_GRANT) || (nxt_state == S_BUSY);
    nxt_over = (nxt_state == S_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      rr_ptr           <= '0;
      hold_q           <= 1'b0;
      tile_cnt_q       <= '0;
      write_oa_granted <= '0;
      icb_sel          <= '0;
      icb_sel_vld      <= 1'b0;
      tiles_done       <= '0;
      oa_calc_over     <= 1'b0;
      err_sticky       <= 1'b0;
    end else begin
      state            <= nxt_state;
      rr_ptr           <= nxt_rr;
      hold_q           <= nxt_hold;
      tile_cnt_q       <= nxt_tc;
      write_oa_granted <= nxt_gnt;
      icb_sel          <= nxt_sel;
      icb_sel_vld      <= nxt_vld;
      tiles_done       <= nxt_tiles;
      oa_calc_over     <= nxt_over;
      err_sticky       <= nxt_err;
    end
  end

endmodule
